// File: rtl/pe_pad_seq.sv
// Per-PE sequencer for one IPAD/WPAD pair: accepts a layer-pass config, paces pops and row swaps.
// Define PE_PAD_SEQ_PERF_EN to add the saturating perf_stall_cnt output.
module pe_pad_seq #(
  parameter int unsigned ConfDWd  = 4,
  parameter int unsigned PConfDWd = 3,
  parameter int unsigned TwWd     = 6,
  parameter int unsigned RowWd    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ConfDWd-1:0]  cfg_iflen,
  input  logic [ConfDWd-1:0]  cfg_popu,
  input  logic [PConfDWd-1:0] cfg_pch,
  input  logic [TwWd-1:0]     cfg_tw,
  input  logic [RowWd-1:0]    cfg_rows,
  input  logic                abort,
  input  logic                tm_end,
  input  logic                out_ready,
  output logic [ConfDWd-1:0]  IFLen,
  output logic [ConfDWd-1:0]  PopU,
  output logic [PConfDWd-1:0] Pch,
  output logic                pop,
  output logic                nxtRow,
  output logic                nxtWRow,
  output logic                stall,
  output logic                start,
  output logic                reset,
  output logic                done,
  output logic                busy,
`ifdef PE_PAD_SEQ_PERF_EN
  output logic [15:0]         perf_stall_cnt,
`endif
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_ROW   = 3'd4,
    S_DONE  = 3'd5,
    S_ABRT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [TwWd-1:0]   tw_q;
  logic [RowWd-1:0]  rows_q;
  logic [TwWd-1:0]   pixcnt_q;
  logic [RowWd-1:0]  rowcnt_q;
  logic              pending_q;

  logic hs;
  logic fire;
  logic pix_last;
  logic row_last;
  logic pop_d, nxtrow_d, start_d, reset_d, done_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and strobe decode; abort overrides every transition
  always_comb begin
    state_d  = state_q;
    hs       = 1'b0;
    fire     = 1'b0;
    pix_last = (pixcnt_q == (tw_q - TwWd'(1)));
    row_last = (rowcnt_q == (rows_q - RowWd'(1)));
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          hs      = 1'b1;
          state_d = ((cfg_tw == '0) || (cfg_rows == '0)) ? S_DONE : S_CLR;
        end
      end
      S_CLR:   state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        fire = (tm_end | pending_q) & out_ready;
        if (fire && pix_last) state_d = S_ROW;
      end
      S_ROW:   state_d = row_last ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      S_ABRT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_ABRT;
      fire    = 1'b0;
    end
    pop_d    = fire;
    nxtrow_d = (state_q == S_ROW) && !row_last && !abort;
    start_d  = (state_q == S_START) && !abort;
    done_d   = (state_q == S_DONE) && !abort;
    reset_d  = ((state_q == S_CLR) && !abort) || (state_q == S_ABRT);
  end

  // Latched config, pixel/row counters, pending tm_end and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IFLen     <= '0;
      PopU      <= '0;
      Pch       <= '0;
      tw_q      <= '0;
      rows_q    <= '0;
      pixcnt_q  <= '0;
      rowcnt_q  <= '0;
      pending_q <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (hs) begin
        IFLen  <= cfg_iflen;
        PopU   <= cfg_popu;
        Pch    <= cfg_pch;
        tw_q   <= cfg_tw;
        rows_q <= cfg_rows;
      end
      if (state_q == S_CLR) begin
        pixcnt_q  <= '0;
        rowcnt_q  <= '0;
        pending_q <= 1'b0;
      end
      if ((state_q == S_RUN) && !abort) begin
        if (fire) begin
          pending_q <= 1'b0;
          if (!pix_last) pixcnt_q <= pixcnt_q + TwWd'(1);
        end else if (tm_end && !out_ready) begin
          pending_q <= 1'b1;
          if (pending_q) err <= 1'b1;
        end
      end
      if (nxtrow_d) begin
        rowcnt_q <= rowcnt_q + RowWd'(1);
        pixcnt_q <= '0;
      end
    end
  end

  // Registered strobes and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      pop       <= 1'b0;
      nxtRow    <= 1'b0;
      nxtWRow   <= 1'b0;
      start     <= 1'b0;
      reset     <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      pop       <= pop_d;
      nxtRow    <= nxtrow_d;
      nxtWRow   <= nxtrow_d;
      start     <= start_d;
      reset     <= reset_d;
      done      <= done_d;
    end
  end

  assign stall = (state_q == S_RUN) & ~out_ready;

`ifdef PE_PAD_SEQ_PERF_EN
  // Saturating count of stalled RUN cycles, restarted at each pass start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          perf_stall_cnt <= '0;
    else if (state_q == S_START)         perf_stall_cnt <= '0;
    else if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pe_pad_seq.sv
// Directed bench for pe_pad_seq: per-cycle compare against an event-scheduling model plus literal checks.
module tb_pe_pad_seq;
  localparam int BIG = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_iflen = '0;
  logic [3:0] cfg_popu = '0;
  logic [2:0] cfg_pch = '0;
  logic [5:0] cfg_tw = '0;
  logic [3:0] cfg_rows = '0;
  logic       abort = 1'b0;
  logic       tm_end = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] IFLen, PopU;
  logic [2:0] Pch;
  logic       pop, nxtRow, nxtWRow, stall, start, reset, done, busy, err;
`ifdef PE_PAD_SEQ_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  pe_pad_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_iflen(cfg_iflen), .cfg_popu(cfg_popu), .cfg_pch(cfg_pch),
    .cfg_tw(cfg_tw), .cfg_rows(cfg_rows), .abort(abort), .tm_end(tm_end),
    .out_ready(out_ready), .IFLen(IFLen), .PopU(PopU), .Pch(Pch), .pop(pop),
    .nxtRow(nxtRow), .nxtWRow(nxtWRow), .stall(stall), .start(start),
    .reset(reset), .done(done), .busy(busy),
`ifdef PE_PAD_SEQ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Model: consequences of each input event are scheduled at absolute cycle numbers
  bit s_pop[64], s_nxt[64], s_rst[64], s_start[64], s_done[64];
  int idle_at, run_at, err_from, cfg_from, start_cyc, abrt_cyc;
  int m_tw, m_rows, m_pix, m_row, perf_exp, perf_n;
  bit m_pend;
  logic [3:0] old_iflen, new_iflen, old_popu, new_popu;
  logic [2:0] old_pch, new_pch;

  function automatic void model_init();
    for (int k = 0; k < 64; k++) begin
      s_pop[k] = 0; s_nxt[k] = 0; s_rst[k] = 0; s_start[k] = 0; s_done[k] = 0;
    end
    idle_at = 0; run_at = -1; err_from = BIG; cfg_from = 0; start_cyc = -1; abrt_cyc = -1;
    m_tw = 0; m_rows = 0; m_pix = 0; m_row = 0; m_pend = 0; perf_exp = 0;
    old_iflen = '0; new_iflen = '0; old_popu = '0; new_popu = '0; old_pch = '0; new_pch = '0;
  endfunction

  function automatic void sched_cancel(input int c);
    for (int k = 1; k <= 8; k++) begin
      s_pop[(c+k)%64] = 0; s_nxt[(c+k)%64] = 0; s_rst[(c+k)%64] = 0;
      s_start[(c+k)%64] = 0; s_done[(c+k)%64] = 0;
    end
  endfunction

  int n_pop = 0, n_nxt = 0, n_rst = 0, n_start = 0, n_done = 0, n_stall = 0;
  int last_pop = 0, last_rst = 0, last_done = 0;
  int c_i, ix;
  bit idle_c, run_c, keep;
  logic [31:0] got_v, want_v;
  logic [3:0] e_if, e_pu;
  logic [2:0] e_pc;

  // Single compare process: check every cycle, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (!rst_n) begin
      model_init();
    end else begin
      c_i = cyc; ix = c_i % 64;
      idle_c = (c_i >= idle_at);
      run_c  = (run_at >= 0) && (c_i >= run_at);
      if (c_i >= cfg_from) begin e_if = new_iflen; e_pu = new_popu; e_pc = new_pch; end
      else begin e_if = old_iflen; e_pu = old_popu; e_pc = old_pch; end
      want_v = {11'd0, idle_c, !idle_c, s_pop[ix], s_nxt[ix], s_nxt[ix], run_c && !out_ready,
                s_start[ix], s_rst[ix], s_done[ix], (c_i >= err_from), e_if, e_pu, e_pc};
      got_v  = {11'd0, cfg_ready, busy, pop, nxtRow, nxtWRow, stall, start, reset, done, err,
                IFLen, PopU, Pch};
      chk("outputs{rdy,busy,pop,nxr,nxw,stall,start,rst,done,err,if,pu,pc}", got_v, want_v);
`ifdef PE_PAD_SEQ_PERF_EN
      chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'(perf_exp));
`endif
      if (pop) begin n_pop++; last_pop = c_i; end
      if (nxtRow) n_nxt++;
      if (reset) begin n_rst++; last_rst = c_i; end
      if (start) n_start++;
      if (done) begin n_done++; last_done = c_i; end
      if (stall) n_stall++;
      s_pop[ix] = 0; s_nxt[ix] = 0; s_rst[ix] = 0; s_start[ix] = 0; s_done[ix] = 0;

      perf_n = perf_exp;
      if (c_i == start_cyc) perf_n = 0;
      else if (run_c && !out_ready && perf_exp < 65535) perf_n = perf_exp + 1;

      if (idle_c) begin
        if (cfg_valid) begin
          if (c_i >= cfg_from) begin old_iflen = new_iflen; old_popu = new_popu; old_pch = new_pch; end
          new_iflen = cfg_iflen; new_popu = cfg_popu; new_pch = cfg_pch; cfg_from = c_i + 1;
          if (cfg_tw == 0 || cfg_rows == 0) begin
            s_done[(c_i+2)%64] = 1; idle_at = c_i + 2;
          end else begin
            s_rst[(c_i+2)%64] = 1; s_start[(c_i+3)%64] = 1;
            start_cyc = c_i + 2; run_at = c_i + 3; idle_at = BIG;
            m_tw = int'(cfg_tw); m_rows = int'(cfg_rows); m_pix = 0; m_row = 0; m_pend = 0;
          end
        end
      end else if (abort) begin
        keep = (c_i == abrt_cyc);
        sched_cancel(c_i);
        if (keep) s_rst[(c_i+1)%64] = 1;
        s_rst[(c_i+2)%64] = 1;
        run_at = -1; start_cyc = -1; idle_at = c_i + 2; abrt_cyc = c_i + 1;
      end else if (run_c) begin
        if ((tm_end || m_pend) && out_ready) begin
          s_pop[(c_i+1)%64] = 1; m_pend = 0; m_pix++;
          if (m_pix == m_tw) begin
            m_pix = 0; m_row++; run_at = -1;
            if (m_row == m_rows) begin
              s_done[(c_i+3)%64] = 1; idle_at = c_i + 3;
            end else begin
              s_nxt[(c_i+2)%64] = 1; run_at = c_i + 2;
            end
          end
        end else if (tm_end && !out_ready) begin
          if (m_pend && err_from == BIG) err_from = c_i + 1;
          m_pend = 1;
        end
      end
      perf_exp = perf_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hs_cyc, rise_cyc, ab_cyc;
  int b_pop, b_nxt, b_rst, b_start, b_done, b_stall;

  task automatic snap();
    b_pop = n_pop; b_nxt = n_nxt; b_rst = n_rst; b_start = n_start; b_done = n_done; b_stall = n_stall;
  endtask

  task automatic send_cfg(input logic [3:0] il, input logic [3:0] pu, input logic [2:0] pc,
                          input logic [5:0] tw, input logic [3:0] rows);
    int k = 0;
    while (!cfg_ready && k < 50) begin tick(1); k++; end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_iflen = il; cfg_popu = pu; cfg_pch = pc; cfg_tw = tw; cfg_rows = rows;
    cfg_valid = 1'b1; hs_cyc = cyc;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy_pop_done", {29'd0, busy, pop, done}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Two rows of three pixels with tm_end every 4 cycles
    snap(); out_ready = 1'b1;
    send_cfg(4'd6, 4'd4, 3'd2, 6'd3, 4'd2);
    for (int i = 0; i < 40; i++) begin tm_end = (i % 4 == 3); tick(1); end
    tm_end = 1'b0;
    chk("t1_pops", 32'(n_pop - b_pop), 32'd6);
    chk("t1_nxtrow", 32'(n_nxt - b_nxt), 32'd1);
    chk("t1_resets", 32'(n_rst - b_rst), 32'd1);
    chk("t1_starts", 32'(n_start - b_start), 32'd1);
    chk("t1_dones", 32'(n_done - b_done), 32'd1);
    chk("t1_reset_lat", 32'(last_rst - hs_cyc), 32'd2);
    chk("t1_done_after_pop", 32'(last_done - last_pop), 32'd2);
    chk("t1_cfg_held", {21'd0, IFLen, PopU, Pch}, {21'd0, 4'd6, 4'd4, 3'd2});
    chk("t1_err", 32'(err), 32'd0);

    // One tm_end under back-pressure, released after five stalled cycles
    snap();
    send_cfg(4'd3, 4'd1, 3'd1, 6'd2, 4'd1);
    tick(2);
    out_ready = 1'b0; tm_end = 1'b1; tick(1);
    tm_end = 1'b0; tick(4);
    out_ready = 1'b1; rise_cyc = cyc; tick(2);
    chk("t2_pop_after_rise", 32'(last_pop - rise_cyc), 32'd1);
    tm_end = 1'b1; tick(1); tm_end = 1'b0; tick(6);
    chk("t2_stall_cycles", 32'(n_stall - b_stall), 32'd5);
    chk("t2_pops", 32'(n_pop - b_pop), 32'd2);
    chk("t2_dones", 32'(n_done - b_done), 32'd1);
    chk("t2_err", 32'(err), 32'd0);

    // Two tm_end strobes while blocked: overrun flagged, only one pop
    snap();
    send_cfg(4'd3, 4'd1, 3'd1, 6'd2, 4'd1);
    tick(2);
    out_ready = 1'b0; tm_end = 1'b1; tick(1);
    tm_end = 1'b0; tick(1);
    tm_end = 1'b1; tick(1);
    tm_end = 1'b0; tick(2);
    out_ready = 1'b1; tick(3);
    chk("t3_pair_pops", 32'(n_pop - b_pop), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    tm_end = 1'b1; tick(1); tm_end = 1'b0; tick(6);
    chk("t3_pops", 32'(n_pop - b_pop), 32'd2);
    chk("t3_dones", 32'(n_done - b_done), 32'd1);

    // Zero-width pass: done two cycles after the handshake, nothing else
    snap();
    send_cfg(4'd5, 4'd5, 3'd5, 6'd0, 4'd3);
    tick(5);
    chk("t4_done_lat", 32'(last_done - hs_cyc), 32'd2);
    chk("t4_dones", 32'(n_done - b_done), 32'd1);
    chk("t4_no_rst_start_pop", 32'((n_rst - b_rst) + (n_start - b_start) + (n_pop - b_pop)), 32'd0);
    chk("t4_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // Abort after the second pop, then an immediate new pass
    snap();
    send_cfg(4'd6, 4'd4, 3'd2, 6'd4, 4'd2);
    for (int k = 0; k < 30 && (n_pop - b_pop) < 2; k++) begin
      tm_end = 1'b1; tick(1); tm_end = 1'b0; tick(1);
    end
    chk("t5_two_pops", 32'(n_pop - b_pop), 32'd2);
    abort = 1'b1; ab_cyc = cyc; tick(1);
    abort = 1'b0;
    send_cfg(4'd1, 4'd1, 3'd1, 6'd1, 4'd1);
    chk("t5_accept_lat", 32'(hs_cyc - ab_cyc), 32'd2);
    chk("t5_abort_reset_lat", 32'(last_rst - ab_cyc), 32'd2);
    chk("t5_resets", 32'(n_rst - b_rst), 32'd2);
    chk("t5_no_done", 32'(n_done - b_done), 32'd0);
    tick(2); tm_end = 1'b1; tick(1); tm_end = 1'b0; tick(4);
    chk("t5_pops", 32'(n_pop - b_pop), 32'd3);
    chk("t5_dones", 32'(n_done - b_done), 32'd1);

    // Asynchronous reset in the middle of a stalled RUN
    send_cfg(4'd6, 4'd4, 3'd2, 6'd3, 4'd2);
    tick(3);
    out_ready = 1'b0; tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t6_outs_zero", {10'd0, busy, pop, nxtRow, nxtWRow, stall, start, reset, done, err,
                         IFLen, PopU, Pch}, 32'd0);
`ifdef PE_PAD_SEQ_PERF_EN
    chk("t6_perf_zero", 32'(perf_stall_cnt), 32'd0);
`endif
    out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("t6_idle_after", {30'd0, cfg_ready, busy}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_pad_seq.md
Name: pe_pad_seq

Overview:
- Per-PE sequencer that drives the input-pad control bundle (IFLen, PopU, Pch, pop, nxtRow, stall, start, reset, done) and the weight-pad nxtWRow strobe.
- Accepts one layer-pass configuration through a valid/ready handshake, then paces pixel pops and row swaps.
- Pop pacing follows end-of-Tm strobes from the weight pad and back-pressure from the accumulate unit.
- Sits between the PE-array configuration bus and one PE's IPAD/WPAD pair.

Parameters:
- ConfDWd, 4, width of IFLen/PopU.
- PConfDWd, 3, width of Pch.
- TwWd, 6, width of the output-pixels-per-row count.
- RowWd, 4, width of the IF-rows-per-pass count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  sequencer can accept config.
- cfg_iflen  in  ConfDWd  R*Pch.
- cfg_popu  in  ConfDWd  (U-1)*Pch+1.
- cfg_pch  in  PConfDWd  channel tile.
- cfg_tw  in  TwWd  pops per row (Tw).
- cfg_rows  in  RowWd  IF rows per pass.
- abort  in  1  cancel current pass.
- tm_end  in  1  one-cycle strobe from WPAD: Tm finished for current pixel.
- out_ready  in  1  accumulate unit can accept results.
- IFLen  out  ConfDWd  latched cfg_iflen.
- PopU  out  ConfDWd  latched cfg_popu.
- Pch  out  PConfDWd  latched cfg_pch.
- pop  out  1  IPAD pop strobe.
- nxtRow  out  1  IPAD row swap strobe.
- nxtWRow  out  1  WPAD row advance strobe.
- stall  out  1  hold pads.
- start  out  1  pass start strobe.
- reset  out  1  pad clear strobe.
- done  out  1  pass complete strobe.
- busy  out  1  state != IDLE.
- err  out  1  sticky overrun flag.

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0, except cfg_ready=1. Latched config 0. Counters 0. err 0.
- All strobe outputs are registered, one cycle wide.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch all cfg_* fields.
  - If cfg_tw==0 or cfg_rows==0, go to DONE (no start, no pop).
  - Otherwise go to CLR.
- CLR: reset=1 for one cycle; pixcnt=0, rowcnt=0, pending=0; next state START.
- START: start=1 for one cycle; next state RUN.
- RUN:
  - stall = ~out_ready (combinational from a registered state decode).
  - A pop fires when (tm_end|pending)&out_ready. pop is asserted the cycle after the fire condition.
  - If tm_end arrives while out_ready=0, set pending. It clears when its pop fires.
  - If tm_end arrives while pending=1 and out_ready=0, set err (sticky until reset); the extra strobe is dropped.
  - Each fired pop increments pixcnt. When it fires with pixcnt==cfg_tw-1, go to ROW.
- ROW:
  - If rowcnt==cfg_rows-1, go to DONE.
  - Otherwise nxtRow=nxtWRow=1 for one cycle, rowcnt++, pixcnt=0, return to RUN.
- DONE: done=1 for one cycle; next state IDLE.
- tm_end outside RUN is ignored.
- Abort:
  - In any non-IDLE state, abort forces state ABRT. ABRT asserts reset=1 for one cycle, then goes to IDLE. No done is issued.
  - abort takes priority over every other transition.
  - abort in IDLE does nothing.
- Pass length: exactly cfg_tw*cfg_rows pops, and cfg_rows-1 nxtRow pulses. There is no nxtRow after the last row.
- Counter compares are exact-width. pixcnt and rowcnt never wrap.

Optional Feature:
- Macro: PE_PAD_SEQ_PERF_EN.
- When defined: adds output perf_stall_cnt [15:0]. It counts RUN cycles with stall=1, saturates at 16'hFFFF, clears in START, and holds its value in IDLE.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Config iflen=6, popu=4, pch=2, tw=3, rows=2; tm_end every 4 cycles; out_ready=1 -> reset, then start, then 6 pops each 1 cycle after tm_end; 1 nxtRow+nxtWRow after pop 3; done 2 cycles after pop 6; IFLen=6, PopU=4, Pch=2 held.
- tw=2, rows=1; out_ready=0 while tm_end pulses once; out_ready=1 five cycles later -> stall high for those 5 cycles; pop 1 cycle after out_ready rises; err=0.
- Two tm_end pulses during out_ready=0 -> err=1 and stays 1 through the next pass; only one pop is issued for the pair.
- cfg_tw=0, rows=3 -> done exactly 2 cycles after handshake; no reset/start/pop; cfg_ready returns to 1.
- abort after the 2nd pop of a tw=4, rows=2 pass -> reset pulse next cycle, then IDLE with cfg_ready=1; no done; a new config is accepted immediately.
- rst_n asserted mid-RUN (asynchronous, mid-cycle) -> all outputs 0 and cfg_ready=1 immediately; with PE_PAD_SEQ_PERF_EN, perf_stall_cnt=0.
